modular_square_iter_seq: RTL
============================

// Module: modular_square_iter_seq
// PURPOSE
//  Iteration sequencer for a free-running modular squaring core (VDF evaluation).
//  Accepts a job {x, T, checkpoint interval}, seeds the core once, counts its
//  per-iteration valid pulses, and returns x^(2^T) plus optional intermediate
//  checkpoints through a DEPTH-entry result FIFO with ready/valid backpressure.
//  Sits between the host command interface and the squaring core.
// PARAMETERS
//  MOD_LEN  1024  operand/result width in bits
//  ITER_W   64    width of iteration count and iteration index
//  CHKPT_W  16    width of checkpoint interval (0 = no checkpoints)
//  DEPTH    4     result FIFO entries (power of 2, >=2)
//  TIMEOUT  4096  max cycles from core_start, or between core_valid pulses, before error
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  reset_n      in   1        asynchronous, active-low reset
//  cmd_valid    in   1        job request
//  cmd_ready    out  1        job accepted when cmd_valid & cmd_ready
//  cmd_x        in   MOD_LEN  seed value
//  cmd_iters    in   ITER_W   number of squarings T
//  cmd_chkpt    in   CHKPT_W  checkpoint interval C
//  abort        in   1        cancel current job
//  core_start   out  1        one-cycle seed pulse to core
//  core_sq_in   out  MOD_LEN  seed to core, valid while core_start=1
//  core_sq_out  in   MOD_LEN  core current result
//  core_valid   in   1        one-cycle pulse per completed squaring
//  res_valid    out  1        FIFO head valid
//  res_ready    in   1        pop FIFO head when res_valid & res_ready
//  res_y        out  MOD_LEN  result value
//  res_iter     out  ITER_W   iteration index of res_y
//  res_last     out  1        1 = final result of job
//  busy         out  1        state RUN
//  err_timeout  out  1        sticky: core timed out
//  err_ovf      out  1        sticky: FIFO overflow
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty; all outputs 0 except cmd_ready=1; counters 0.
//  States: IDLE, RUN, ERR. cmd_ready = (IDLE & FIFO empty) | ERR.
//  Accept (cycle N): x,T,C registered; errors cleared; FIFO flushed if in ERR.
//   T=0: push {x,0,last=1} at N, res_valid in N+1, stay IDLE, no core_start.
//   T>0: core_start=1 and core_sq_in=x in cycle N+1 only; enter RUN; k=0; cdn=C.
//  RUN, each core_valid: k<=k+1 (k counts 1..T); cdn decrements, reloads to C at 0.
//   k+1==T: push {core_sq_out,T,1}, go IDLE; further core_valid ignored.
//   else if C!=0 and cdn==1: push {core_sq_out,k+1,0} (every Cth iteration).
//   core_valid outside RUN ignored.
//  FIFO: push visible on res_* next cycle; first-word-fall-through; push and pop
//   same cycle always legal, incl. when full (no overflow). Push when full and no
//   pop: entry dropped, err_ovf=1, go ERR. Core cannot be stalled; size DEPTH/C.
//  Timeout: cycle counter reset by core_start and core_valid; reaching TIMEOUT
//   in RUN: err_timeout=1, go ERR. FIFO contents retained in ERR until next accept.
//  abort (any state, highest priority over core_valid): go IDLE, flush FIFO,
//   clear errors, core_start suppressed if pending. cmd_valid same cycle ignored.
//  Arithmetic: k, T compared at ITER_W bits, no wrap (T<=2^ITER_W-1).
//  Async reset mid-job: immediate return to reset values; core output ignored.
// TESTING
//  1 T=0, x=5 -> res_valid next cycle, res_y=5, res_iter=0, res_last=1, no core_start.
//  2 Model core N=3233, x=2, T=10, C=0 -> single result 2^1024 mod N, iter=10, last=1.
//  3 T=8, C=2, res_ready=1 -> 4 results, iter 2,4,6,8, only iter 8 last=1.
//  4 T=20, C=1, DEPTH=4, res_ready=0 -> 4 stored, 5th push: err_ovf=1, ERR, cmd_ready=1.
//  5 Core never asserts core_valid -> err_timeout=1 TIMEOUT cycles after core_start.
//  6 abort at k=3 of T=10 -> IDLE, FIFO empty, later core_valid ignored, new job runs.

Source files
------------

// File: rtl/modular_square_iter_seq.sv
// Iteration sequencer for a free-running modular squaring core.
// Seeds the core, counts squarings and queues checkpoints/final result.
module modular_square_iter_seq #(
  parameter int MOD_LEN = 1024,
  parameter int ITER_W  = 64,
  parameter int CHKPT_W = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [MOD_LEN-1:0] cmd_x,
  input  logic [ITER_W-1:0]  cmd_iters,
  input  logic [CHKPT_W-1:0] cmd_chkpt,
  input  logic               abort,
  output logic               core_start,
  output logic [MOD_LEN-1:0] core_sq_in,
  input  logic [MOD_LEN-1:0] core_sq_out,
  input  logic               core_valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MOD_LEN-1:0] res_y,
  output logic [ITER_W-1:0]  res_iter,
  output logic               res_last,
  output logic               busy,
  output logic               err_timeout,
  output logic               err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [MOD_LEN-1:0] x_q, x_d;
  logic [ITER_W-1:0]  t_q, t_d;
  logic [CHKPT_W-1:0] c_q, c_d;
  logic [ITER_W-1:0]  k_q, k_d;
  logic [CHKPT_W-1:0] cdn_q, cdn_d;
  logic               start_q, start_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               eto_q, eto_d;
  logic               eov_q, eov_d;

  logic [MOD_LEN-1:0] mem_y [DEPTH];
  logic [ITER_W-1:0]  mem_it [DEPTH];
  logic               mem_last [DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;

  logic               empty, full, accept, pop;
  logic               push, flush, ovf, wr_en;
  logic [MOD_LEN-1:0] push_y;
  logic [ITER_W-1:0]  push_it;
  logic               push_last;
  logic [ITER_W-1:0]  k_inc;
  logic               is_last, is_chk;
  logic [AW-1:0]      widx;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = !empty && res_ready;
  assign k_inc   = k_q + ITER_W'(1);
  assign is_last = (k_inc == t_q);
  assign is_chk  = (c_q != '0) && (cdn_q == CHKPT_W'(1));

  assign cmd_ready = ((state_q == S_IDLE) && empty)
                   || (state_q == S_ERR);
  assign accept    = cmd_valid && cmd_ready && !abort;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    t_d       = t_q;
    c_d       = c_q;
    k_d       = k_q;
    cdn_d     = cdn_q;
    start_d   = 1'b0;
    tmo_d     = tmo_q;
    eto_d     = eto_q;
    eov_d     = eov_q;
    push      = 1'b0;
    push_y    = '0;
    push_it   = '0;
    push_last = 1'b0;
    flush     = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      eto_d   = 1'b0;
      eov_d   = 1'b0;
      tmo_d   = '0;
    end else if (accept) begin
      x_d   = cmd_x;
      t_d   = cmd_iters;
      c_d   = cmd_chkpt;
      k_d   = '0;
      cdn_d = cmd_chkpt;
      eto_d = 1'b0;
      eov_d = 1'b0;
      tmo_d = '0;
      flush = (state_q == S_ERR);
      if (cmd_iters == '0) begin
        push      = 1'b1;
        push_y    = cmd_x;
        push_last = 1'b1;
        state_d   = S_IDLE;
      end else begin
        start_d = 1'b1;
        state_d = S_RUN;
      end
    end else if (state_q == S_RUN) begin
      if (core_valid) begin
        k_d   = k_inc;
        cdn_d = (cdn_q <= CHKPT_W'(1)) ? c_q : cdn_q - CHKPT_W'(1);
        tmo_d = TW'(1);
        if (is_last) begin
          push      = 1'b1;
          push_y    = core_sq_out;
          push_it   = k_inc;
          push_last = 1'b1;
          state_d   = S_IDLE;
        end else if (is_chk) begin
          push    = 1'b1;
          push_y  = core_sq_out;
          push_it = k_inc;
        end
      end else if (start_q) begin
        tmo_d = TW'(1);
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        eto_d   = 1'b1;
        state_d = S_ERR;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    // A full FIFO with no pop drops the entry and halts the job
    ovf = push && full && !pop && !flush;
    if (ovf) begin
      eov_d   = 1'b1;
      state_d = S_ERR;
    end
  end

  assign wr_en = push && !ovf;
  assign widx  = flush ? '0 : wr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      t_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      cdn_q   <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      eto_q   <= 1'b0;
      eov_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      t_q     <= t_d;
      c_q     <= c_d;
      k_q     <= k_d;
      cdn_q   <= cdn_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      eto_q   <= eto_d;
      eov_q   <= eov_d;
      if (flush) begin
        rd_q  <= '0;
        wr_q  <= AW'(wr_en);
        cnt_q <= CW'(wr_en);
      end else begin
        if (wr_en) wr_q <= wr_q + AW'(1);
        if (pop)   rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + CW'(wr_en) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_y[widx]    <= push_y;
      mem_it[widx]   <= push_it;
      mem_last[widx] <= push_last;
    end
  end

  assign res_valid   = !empty;
  assign res_y       = empty ? '0 : mem_y[rd_q];
  assign res_iter    = empty ? '0 : mem_it[rd_q];
  assign res_last    = !empty && mem_last[rd_q];
  assign core_start  = start_q && !abort;
  assign core_sq_in  = core_start ? x_q : '0;
  assign busy        = (state_q == S_RUN);
  assign err_timeout = eto_q;
  assign err_ovf     = eov_q;

endmodule
